note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Upstream feeder for the tone generator. Holds a small programmable melody table of (note, octave, duration) entries and plays it back in real time, driving the tone generator's 32-bit frequency and on/off inputs. Writes come from the control/keypad logic; a single start pulse plays the table until an end marker, a stop request, or the last entry.

Parameters:
- FCLK, 50_000_000, clock frequency in Hz.
- TICK_HZ, 100, duration tick rate in Hz. TICK_CYC = FCLK/TICK_HZ cycles per tick; must divide exactly.
- DEPTH, 16, number of table entries; must be a power of 2, at least 2.
- GAP_TICKS, 1, silent ticks inserted after every entry (articulation gap); 0 means no gap.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, table write strobe.
- wr_addr, in, $clog2(DEPTH), table write address.
- wr_note, in, 4, note code: 0 = rest; 1..12 = C..B; 13..15 = rest.
- wr_oct, in, 2, octave shift 0..3 (x1, x2, x4, x8).
- wr_dur, in, 8, duration in ticks; 0 = end-of-song marker.
- start, in, 1, single-cycle play request.
- stop, in, 1, single-cycle abort request.
- freq, out, 32, frequency to the tone generator, in Hz.
- onOff, out, 1, 1 = tone audible.
- busy, out, 1, high from fetch through the last gap.
- done, out, 1, one-cycle pulse at normal completion.
- idx, out, $clog2(DEPTH), index of the entry being played.

Behaviour:
- Reset is asynchronous and active-low. On reset: freq=0, onOff=0, busy=0, done=0, idx=0, state=IDLE, all counters 0. Table contents are not reset.
- Writes take effect on the next cycle. Writes are accepted in any state, including during playback. An entry is sampled only when it is fetched.
- Base frequency table (octave 0): 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494 Hz for codes 1..12. freq = base << oct, zero-extended to 32 bits.
- FSM states: IDLE, FETCH, PLAY, GAP, DONE.
  - IDLE: start -> FETCH with idx=0, busy=1.
  - FETCH (1 cycle): read entry[idx].
    - dur=0 -> DONE.
    - Otherwise load dur_cnt=dur, clear the prescaler, go to PLAY.
    - On entering PLAY, freq/onOff are registered: freq = table value and onOff=1 for a tone; freq=0 and onOff=0 for a rest.
  - PLAY: dur_cnt decrements on each tick (prescaler reaching TICK_CYC-1). When the tick arrives with dur_cnt=1:
    - GAP_TICKS>0 -> go to GAP with freq=0, onOff=0.
    - GAP_TICKS=0 -> go directly to next-entry handling.
    - Each note therefore lasts exactly dur*TICK_CYC cycles.
  - GAP: hold for GAP_TICKS*TICK_CYC cycles, then next-entry handling.
  - Next-entry handling:
    - If idx=DEPTH-1 -> DONE (no wrap unless the optional feature is on).
    - Otherwise idx+1 -> FETCH.
  - DONE (1 cycle): done=1, busy=0, freq=0, onOff=0, then IDLE. idx holds its last value until the next start.
- Latency: start in cycle N gives FETCH in N+1; freq/onOff are valid in N+2.
- start while busy is ignored.
- stop in any non-IDLE state: next cycle is IDLE with freq=0, onOff=0, busy=0, and no done pulse.
- Simultaneous start and stop in IDLE: stop wins and nothing plays.
- Simultaneous stop and a write: the write still happens.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: adds input loop (1 bit), sampled during next-entry handling and at the end marker.
  - With loop=1, idx=DEPTH-1 or dur=0 goes to FETCH at idx=0 instead of DONE.
  - If entry 0 itself has dur=0, go to DONE regardless, to prevent a zero-time spin.
  - stop still aborts.
- Undefined: no loop port; behaviour is exactly as above.

Decomposition:
- Package seq_pkg:
  - state enum.
  - entry struct {note[3:0], oct[1:0], dur[7:0]}.
  - NOTE_REST constant.
  - Base-frequency lookup function note_hz(note) returning 32 bits, 0 for rest codes.
- One sub-module, tick_prescaler (params FCLK, TICK_HZ; inputs clk, reset_n, clr; output tick pulse). It counts 0..TICK_CYC-1 and pulses on the wrap; clr forces the count to 0.
- Table is a register array inside note_sequencer.

Test Plan (FCLK=1000, TICK_HZ=100 so TICK_CYC=10; DEPTH=4; GAP_TICKS=1):
1. Table {A,oct0,dur2},{C,oct1,dur1},{end}; start -> freq=440, onOff=1 for 20 cycles; then freq=0/onOff=0 for 10 cycles; freq=524 for 10 cycles; gap of 10; done pulse; busy low.
2. Rest entry {0,0,3} followed by end -> freq=0, onOff=0 for 30 cycles, then 10 gap cycles, then done; busy high throughout.
3. All 4 entries with dur=1, no end marker -> idx steps 0..3; done fires after 4*(10+10) cycles plus fetch cycles; idx=3 at done.
4. stop asserted mid-PLAY of entry 1 -> next cycle state IDLE, freq=0, onOff=0, busy=0, no done pulse; a restart begins at idx=0.
5. Assert reset_n=0 asynchronously mid-note -> outputs clear immediately without waiting for clk; table contents survive and replay identically.
6. start pulsed while busy, and a write to entry 2 while playing entry 0 -> the extra start is ignored; entry 2 plays its new value.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and the note-to-frequency lookup for the melody sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        PLAY  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] oct;
        logic [7:0] dur;
    } entry_t;

    localparam logic [3:0] NOTE_REST = 4'd0;

    // Octave-0 pitches for C..B; codes 0 and 13..15 are rests.
    function automatic logic [31:0] note_hz(input logic [3:0] note);
        case (note)
            4'd1:    return 32'd262;
            4'd2:    return 32'd277;
            4'd3:    return 32'd294;
            4'd4:    return 32'd311;
            4'd5:    return 32'd330;
            4'd6:    return 32'd349;
            4'd7:    return 32'd370;
            4'd8:    return 32'd392;
            4'd9:    return 32'd415;
            4'd10:   return 32'd440;
            4'd11:   return 32'd466;
            4'd12:   return 32'd494;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing one tick every FCLK/TICK_HZ cycles; clr restarts the count.
module tick_prescaler #(
    parameter int FCLK    = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int TICK_CYC = FCLK / TICK_HZ;
    localparam int CW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_CYC - 1));
    assign tick = wrap && !clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays a programmable (note, octave, duration) table into the tone generator.
// Optional SEQ_LOOP_EN adds a loop input that restarts at entry 0 instead of finishing.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int FCLK      = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DEPTH     = 16,
    parameter int GAP_TICKS = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_note,
    input  logic [1:0]    wr_oct,
    input  logic [7:0]    wr_dur,
    input  logic          start,
    input  logic          stop,
`ifdef SEQ_LOOP_EN
    input  logic          loop,
`endif
    output logic [31:0]   freq,
    output logic          onOff,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] idx
);
    localparam logic [15:0]   GAP16 = 16'(GAP_TICKS);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    state_t      state;
    entry_t      tbl [DEPTH];
    entry_t      cur;
    logic [7:0]  dur_cnt;
    logic [15:0] gap_cnt;
    logic        tick;
    logic        clr;
    logic        loop_in;
    logic [31:0] tone_hz;
    logic        is_tone;
    logic        next_done;
    logic        marker_done;

`ifdef SEQ_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign cur     = tbl[idx];
    assign is_tone = (cur.note != NOTE_REST) && (cur.note <= 4'd12);
    assign tone_hz = note_hz(cur.note) << cur.oct;
    assign clr     = (state == FETCH);

    // Finishing after the last entry or an end marker, unless looping back is allowed.
    // A marker at entry 0 always finishes so a looping empty song cannot spin.
    assign next_done   = (idx == LAST) && !loop_in;
    assign marker_done = !loop_in || (idx == '0);

    tick_prescaler #(
        .FCLK    (FCLK),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            tbl[wr_addr] <= '{note: wr_note, oct: wr_oct, dur: wr_dur};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            freq    <= '0;
            onOff   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state != IDLE) begin
                state <= IDLE;
                freq  <= '0;
                onOff <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state <= FETCH;
                            idx   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (cur.dur == 8'd0) begin
                            if (marker_done) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                freq  <= '0;
                                onOff <= 1'b0;
                            end else begin
                                idx <= '0;
                            end
                        end else begin
                            state   <= PLAY;
                            dur_cnt <= cur.dur;
                            freq    <= is_tone ? tone_hz : 32'd0;
                            onOff   <= is_tone;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            if (dur_cnt == 8'd1) begin
                                if (GAP_TICKS > 0) begin
                                    state   <= GAP;
                                    gap_cnt <= GAP16;
                                    freq    <= '0;
                                    onOff   <= 1'b0;
                                end else if (next_done) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    freq  <= '0;
                                    onOff <= 1'b0;
                                end else begin
                                    state <= FETCH;
                                    idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                                end
                            end else begin
                                dur_cnt <= dur_cnt - 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (gap_cnt == 16'd1) begin
                                if (next_done) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    freq  <= '0;
                                    onOff <= 1'b0;
                                end else begin
                                    state <= FETCH;
                                    idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                                end
                            end else begin
                                gap_cnt <= gap_cnt - 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        freq  <= '0;
                        onOff <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a segment-queue playback model checked every cycle.
module tb_note_sequencer;

    localparam int TC = 10;   // cycles per tick at FCLK=1000, TICK_HZ=100

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [3:0]  wr_note = '0;
    logic [1:0]  wr_oct = '0;
    logic [7:0]  wr_dur = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] freq;
    logic        onOff;
    logic        busy;
    logic        done;
    logic [1:0]  idx;

    int n_cmp = 0;
    int n_err = 0;

    note_sequencer #(
        .FCLK(1000), .TICK_HZ(100), .DEPTH(4), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_oct(wr_oct), .wr_dur(wr_dur),
        .start(start), .stop(stop),
`ifdef SEQ_LOOP_EN
        .loop(1'b0),
`endif
        .freq(freq), .onOff(onOff), .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    // ---------------- model: expected output per cycle as a queue of segments
    typedef struct {
        logic [31:0] f;
        logic        on;
        logic        bsy;
        logic        dn;
        logic        fet;
        int          ix;
    } item_t;

    int    m_note [4];
    int    m_oct  [4];
    int    m_dur  [4];
    item_t q[$];
    item_t exp_c;
    bit    active = 1'b0;
    bit    last_fet = 1'b0;
    int    m_idx = 0;

    function automatic int pitch(int n);
        int tbl [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};
        if (n >= 1 && n <= 12) return tbl[n-1];
        return 0;
    endfunction

    function automatic item_t mk(logic [31:0] f, logic on, logic bsy, logic dn, logic fet, int ix);
        item_t it;
        it.f = f; it.on = on; it.bsy = bsy; it.dn = dn; it.fet = fet; it.ix = ix;
        return it;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin m_note[i] = 0; m_oct[i] = 0; m_dur[i] = 0; end
        exp_c = mk(0, 0, 0, 0, 0, 0);
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete(); active = 0; last_fet = 0; m_idx = 0;
                exp_c = mk(0, 0, 0, 0, 0, 0);
            end else begin
                if (last_fet) begin
                    if (m_dur[m_idx] == 0) begin
                        q.push_back(mk(0, 0, 0, 1, 0, m_idx));
                    end else begin
                        int hz;
                        hz = pitch(m_note[m_idx]) << m_oct[m_idx];
                        for (int c = 0; c < m_dur[m_idx] * TC; c++)
                            q.push_back(mk(hz, hz != 0, 1, 0, 0, m_idx));
                        for (int c = 0; c < TC; c++)
                            q.push_back(mk(0, 0, 1, 0, 0, m_idx));
                        if (m_idx == 3) q.push_back(mk(0, 0, 0, 1, 0, m_idx));
                        else            q.push_back(mk(0, 0, 1, 0, 1, m_idx + 1));
                    end
                end
                if (active) begin
                    if (stop) begin
                        q.delete(); active = 0; last_fet = 0;
                        exp_c = mk(0, 0, 0, 0, 0, m_idx);
                    end else if (q.size() > 0) begin
                        exp_c = q.pop_front();
                        m_idx = exp_c.ix;
                        last_fet = exp_c.fet;
                    end else begin
                        active = 0; last_fet = 0;
                        exp_c = mk(0, 0, 0, 0, 0, m_idx);
                    end
                end else if (start && !stop) begin
                    active = 1; m_idx = 0; last_fet = 1;
                    exp_c = mk(0, 0, 1, 0, 1, 0);
                end else begin
                    exp_c = mk(0, 0, 0, 0, 0, m_idx);
                end
                if (wr_en) begin
                    m_note[wr_addr] = wr_note; m_oct[wr_addr] = wr_oct; m_dur[wr_addr] = wr_dur;
                end
            end
        end
    end

    // ---------------- every-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (freq !== exp_c.f || onOff !== exp_c.on || busy !== exp_c.bsy ||
                done !== exp_c.dn || idx !== 2'(exp_c.ix)) begin
                n_err++;
                $display("FAIL cycle t=%0t: got freq=%0d on=%0b busy=%0b done=%0b idx=%0d want freq=%0d on=%0b busy=%0b done=%0b idx=%0d",
                         $time, freq, onOff, busy, done, idx,
                         exp_c.f, exp_c.on, exp_c.bsy, exp_c.dn, exp_c.ix);
            end
        end
    end

    // ---------------- directed helpers
    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic wr(int a, int n, int o, int d);
        @(negedge clk);
        wr_en = 1; wr_addr = 2'(a); wr_note = 4'(n); wr_oct = 2'(o); wr_dur = 8'(d);
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    // k counts cycles after the start-sampling edge (k=1 is the first FETCH cycle).
    task automatic play(string nm, int exp_k, int pk1, int pf1, int pi1,
                        int pk2, int pf2, int pi2, bit poke, int last_idx);
        int k;
        bit seen;
        start_pulse();
        k = 1; seen = 0;
        while (k <= 200 && !seen) begin
            if (poke && k == 3) begin
                start = 1; wr_en = 1; wr_addr = 2; wr_note = 8; wr_oct = 2; wr_dur = 1;
            end
            if (poke && k == 4) begin start = 0; wr_en = 0; end
            if (k == pk1) begin
                chk({nm, " probe1 freq"}, freq, pf1);
                chk({nm, " probe1 idx"}, 32'(idx), pi1);
            end
            if (k == pk2) begin
                chk({nm, " probe2 freq"}, freq, pf2);
                chk({nm, " probe2 idx"}, 32'(idx), pi2);
            end
            if (done) begin
                seen = 1;
                chk({nm, " done latency"}, k, exp_k);
                chk({nm, " done idx"}, 32'(idx), last_idx);
                chk({nm, " busy at done"}, 32'(busy), 0);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: got no done within 200 cycles want done at %0d", nm, exp_k);
        end
        @(negedge clk);
    endtask

    initial begin
        bit nd;
        repeat (2) @(negedge clk);
        chk("reset freq", freq, 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset idx", 32'(idx), 0);
        reset_n = 1;

        // 1: A4 two ticks, C octave1 one tick, end marker
        wr(0, 10, 0, 2); wr(1, 1, 1, 1); wr(2, 0, 0, 0);
        play("t1", 54, 2, 440, 0, 33, 524, 1, 0, 2);

        // 2: three-tick rest then end
        wr(0, 0, 0, 3); wr(1, 0, 0, 0);
        play("t2", 43, 2, 0, 0, 40, 0, 0, 0, 1);

        // 3: four one-tick entries, no end marker
        wr(0, 1, 0, 1); wr(1, 5, 1, 1); wr(2, 8, 2, 1); wr(3, 12, 3, 1);
        play("t3", 85, 23, 660, 1, 65, 3952, 3, 0, 3);

        // 4: stop during entry 1, then restart from entry 0
        wr(0, 10, 0, 2); wr(1, 1, 1, 1); wr(2, 0, 0, 0);
        start_pulse();
        repeat (35) @(negedge clk);
        chk("t4 pre-stop freq", freq, 524);
        stop = 1;
        @(negedge clk); stop = 0;
        chk("t4 stop busy", 32'(busy), 0);
        chk("t4 stop freq", freq, 0);
        chk("t4 stop onOff", 32'(onOff), 0);
        nd = 0;
        repeat (30) begin @(negedge clk); if (done) nd = 1; end
        chk("t4 no done after stop", 32'(nd), 0);
        play("t4r", 54, 2, 440, 0, 33, 524, 1, 0, 2);

        // 5: asynchronous reset in the middle of a note
        start_pulse();
        repeat (4) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("t5 async freq", freq, 0);
        chk("t5 async onOff", 32'(onOff), 0);
        chk("t5 async busy", 32'(busy), 0);
        @(negedge clk); reset_n = 1;
        play("t5r", 54, 2, 440, 0, 33, 524, 1, 0, 2);

        // 6: extra start while busy is ignored; entry 2 rewritten mid-play
        wr(2, 5, 0, 1); wr(3, 0, 0, 0);
        play("t6", 75, 54, 1568, 2, 2, 440, 0, 1, 3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
